// File: rtl/alu_led_reader.sv
// alu_led_reader: drives the ALU operation/operand selects, then steps the
// LED byte select and samples the 8-bit LED bus to rebuild the 32-bit result
// and (optionally) the flag byte.
// Build option: define ALU_RD_FLAGS_EN to also read the flag byte at select 4.
// Without it only selects 0..3 are visited and flags is held at zero.
module alu_led_reader #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  alu_op_in,
  input  logic [2:0]  ab_sel_in,
  output logic [2:0]  ALU_OP,
  output logic [2:0]  AB_SW,
  output logic [2:0]  F_LED_SW,
  input  logic [7:0]  LED,
  output logic [31:0] result,
  output logic [7:0]  flags,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

`ifdef ALU_RD_FLAGS_EN
  localparam int         NBYTES   = 5;
  localparam logic [2:0] LAST_SEL = 3'd4;
`else
  localparam int         NBYTES   = 4;
  localparam logic [2:0] LAST_SEL = 3'd3;
`endif

  // Counter runs 0..SETTLE-1 while in WAIT; the last value ends the settle.
  localparam logic [3:0] CNT_LAST = 4'(SETTLE - 1);

  state_t     state, state_nx;
  logic [3:0] cnt;
  logic [7:0] shadow    [NBYTES];
  logic [7:0] shadow_nx [NBYTES];
  logic       last_sel;

  assign last_sel = (F_LED_SW == LAST_SEL);

  // Pack the four result bytes, byte 0 in the least significant position.
  function automatic logic [31:0] pack_result(input logic [7:0] b0,
                                              input logic [7:0] b1,
                                              input logic [7:0] b2,
                                              input logic [7:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_WAIT;
      S_WAIT:   if (cnt == CNT_LAST) state_nx = S_SAMPLE;
      S_SAMPLE: state_nx = last_sel ? S_DONE : S_WAIT;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Shadow contents after this cycle's sample, so the final byte can be
  // committed on the same edge that enters DONE.
  always_comb begin
    shadow_nx = shadow;
    if (state == S_SAMPLE) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (F_LED_SW == 3'(i)) shadow_nx[i] = LED;
      end
    end
  end

  // Select drives, settle counter and byte capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_OP   <= '0;
      AB_SW    <= '0;
      F_LED_SW <= '0;
      cnt      <= '0;
      for (int i = 0; i < NBYTES; i++) shadow[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            ALU_OP   <= alu_op_in;
            AB_SW    <= ab_sel_in;
            F_LED_SW <= '0;
            cnt      <= '0;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 4'd1;
        end
        S_SAMPLE: begin
          shadow <= shadow_nx;
          cnt    <= '0;
          // The select stays on the last byte once the walk completes.
          if (!last_sel) F_LED_SW <= F_LED_SW + 3'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Result commit: loaded on the edge entering DONE so that result is
  // already valid while done is high; never updated partially.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else if (state == S_SAMPLE && last_sel) begin
      result <= pack_result(shadow_nx[0], shadow_nx[1], shadow_nx[2], shadow_nx[3]);
    end
  end

`ifdef ALU_RD_FLAGS_EN
  // Flag byte commit, alongside the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= '0;
    end else if (state == S_SAMPLE && last_sel) begin
      flags <= shadow_nx[4];
    end
  end
`else
  assign flags = 8'h00;
`endif

  // Status outputs registered from the next state: busy covers WAIT through
  // DONE, done marks the single DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nx != S_IDLE);
      done <= (state_nx == S_DONE);
    end
  end

endmodule

// File: tb/tb_alu_led_reader.sv
// Testbench for alu_led_reader: a behavioural ALU LED model feeds the DUT,
// and each scenario checks the read-back against the expected word and timing.
module tb_alu_led_reader;

  localparam int S = 2;
`ifdef ALU_RD_FLAGS_EN
  localparam int STEPS = 5;
`else
  localparam int STEPS = 4;
`endif
  localparam int LAT = STEPS * (S + 1);

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  alu_op_in;
  logic [2:0]  ab_sel_in;
  logic [2:0]  ALU_OP;
  logic [2:0]  AB_SW;
  logic [2:0]  F_LED_SW;
  logic [7:0]  LED;
  logic [31:0] result;
  logic [7:0]  flags;
  logic        busy;
  logic        done;

  logic [31:0] f_model;
  logic [7:0]  flag_model;
  logic        glitch;

  int checks = 0;
  int passes = 0;

  alu_led_reader #(.SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start),
    .alu_op_in(alu_op_in), .ab_sel_in(ab_sel_in),
    .ALU_OP(ALU_OP), .AB_SW(AB_SW), .F_LED_SW(F_LED_SW),
    .LED(LED), .result(result), .flags(flags),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // ALU LED model: byte-multiplexed view of f_model plus the flag byte.
  always_comb begin
    LED = 8'h00;
    if (glitch) LED = 8'hFF;
    else begin
      case (F_LED_SW)
        3'd0: LED = f_model[7:0];
        3'd1: LED = f_model[15:8];
        3'd2: LED = f_model[23:16];
        3'd3: LED = f_model[31:24];
        3'd4: LED = flag_model;
        default: LED = 8'h00;
      endcase
    end
  end

  function automatic logic [7:0] exp_flags(input logic [7:0] fl);
`ifdef ALU_RD_FLAGS_EN
    return fl;
`else
    return 8'h00;
`endif
  endfunction

  function automatic int exp_sel(input int m);
    int s;
    s = m / (S + 1);
    if (s > STEPS - 1) s = STEPS - 1;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge; returns 1 time unit after the accepting edge.
  task automatic do_start(input logic [2:0] op, input logic [2:0] ab);
    start = 1'b1;
    alu_op_in = op;
    ab_sel_in = ab;
    tick();
    start = 1'b0;
  endtask

  // Counts edges from the accepting edge until done; -1 if it never comes.
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < LAT + 20) begin
      tick();
      n++;
    end
    if (!done) n = -1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; alu_op_in = 3'd5; ab_sel_in = 3'd6; glitch = 1'b0;
    f_model = 32'hDEAD_BEEF; flag_model = 8'h03;
    tick(); tick();
    rst = 1'b0;
    checks++; if (ALU_OP !== 3'd0) $display("FAIL reset_alu_op: got %0d want 0", ALU_OP); else passes++;
    checks++; if (AB_SW !== 3'd0) $display("FAIL reset_ab_sw: got %0d want 0", AB_SW); else passes++;
    checks++; if (F_LED_SW !== 3'd0) $display("FAIL reset_sel: got %0d want 0", F_LED_SW); else passes++;
    checks++; if (result !== 32'h0) $display("FAIL reset_result: got %h want 0", result); else passes++;
    checks++; if (flags !== 8'h0) $display("FAIL reset_flags: got %h want 0", flags); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passes++;
  endtask

  task automatic test_basic();
    int n;
    f_model = 32'h1234_5678; flag_model = 8'h02;
    do_start(3'b001, 3'b111);
    checks++; if (ALU_OP !== 3'd1) $display("FAIL basic_alu_op: got %0d want 1", ALU_OP); else passes++;
    checks++; if (AB_SW !== 3'd7) $display("FAIL basic_ab_sw: got %0d want 7", AB_SW); else passes++;
    checks++; if (F_LED_SW !== 3'd0) $display("FAIL basic_sel0: got %0d want 0", F_LED_SW); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy_rise: got %b want 1", busy); else passes++;
    wait_done(n);
    checks++; if (n != LAT) $display("FAIL basic_latency: got %0d want %0d", n, LAT); else passes++;
    checks++; if (result !== 32'h1234_5678) $display("FAIL basic_result: got %h want 12345678", result); else passes++;
    checks++; if (flags !== exp_flags(8'h02)) $display("FAIL basic_flags: got %h want %h", flags, exp_flags(8'h02)); else passes++;
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy_done: got %b want 1", busy); else passes++;
    tick();
    checks++; if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b want 0", done); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_fall: got %b want 0", busy); else passes++;
  endtask

  task automatic test_select_seq();
    f_model = $urandom; flag_model = 8'($urandom);
    do_start(3'd4, 3'd2);
    for (int m = 0; m <= LAT; m++) begin
      checks++;
      if (F_LED_SW !== 3'(exp_sel(m)))
        $display("FAIL sel_seq_m%0d: got %0d want %0d", m, F_LED_SW, exp_sel(m));
      else passes++;
      if (m < LAT) tick();
    end
    checks++; if (done !== 1'b1) $display("FAIL sel_seq_done: got %b want 1", done); else passes++;
    checks++; if (result !== f_model) $display("FAIL sel_seq_result: got %h want %h", result, f_model); else passes++;
    tick(); tick(); tick();
    checks++; if (F_LED_SW !== 3'(STEPS - 1)) $display("FAIL sel_idle_hold: got %0d want %0d", F_LED_SW, STEPS - 1); else passes++;
  endtask

  task automatic test_start_while_busy();
    int dones;
    dones = 0;
    f_model = $urandom; flag_model = 8'($urandom);
    do_start(3'd2, 3'd3);
    for (int m = 0; m <= LAT + 2; m++) begin
      if (done) dones++;
      start = (m == 5 || m == LAT);
      alu_op_in = 3'd5;
      ab_sel_in = 3'd1;
      tick();
    end
    start = 1'b0;
    checks++; if (dones != 1) $display("FAIL busy_start_dones: got %0d want 1", dones); else passes++;
    checks++; if (ALU_OP !== 3'd2) $display("FAIL busy_start_alu_op: got %0d want 2", ALU_OP); else passes++;
    checks++; if (AB_SW !== 3'd3) $display("FAIL busy_start_ab_sw: got %0d want 3", AB_SW); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL busy_start_idle: got %b want 0", busy); else passes++;
    checks++; if (result !== f_model) $display("FAIL busy_start_result: got %h want %h", result, f_model); else passes++;
  endtask

  task automatic test_sampling_window();
    f_model = $urandom; flag_model = 8'($urandom);
    do_start(3'd6, 3'd0);
    for (int m = 0; m < LAT; m++) begin
      glitch = ((m % (S + 1)) == 0);
      tick();
    end
    glitch = 1'b0;
    checks++; if (done !== 1'b1) $display("FAIL window_done: got %b want 1", done); else passes++;
    checks++; if (result !== f_model) $display("FAIL window_result: got %h want %h", result, f_model); else passes++;
    checks++; if (flags !== exp_flags(flag_model)) $display("FAIL window_flags: got %h want %h", flags, exp_flags(flag_model)); else passes++;
    tick();
  endtask

  task automatic test_reset_mid();
    int dones;
    int n;
    f_model = $urandom; flag_model = 8'($urandom);
    do_start(3'd6, 3'd4);
    for (int m = 0; m < 7; m++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (ALU_OP !== 3'd0) $display("FAIL midrst_alu_op: got %0d want 0", ALU_OP); else passes++;
    checks++; if (AB_SW !== 3'd0) $display("FAIL midrst_ab_sw: got %0d want 0", AB_SW); else passes++;
    checks++; if (F_LED_SW !== 3'd0) $display("FAIL midrst_sel: got %0d want 0", F_LED_SW); else passes++;
    checks++; if (result !== 32'h0) $display("FAIL midrst_result: got %h want 0", result); else passes++;
    checks++; if (flags !== 8'h0) $display("FAIL midrst_flags: got %h want 0", flags); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passes++;
    dones = 0;
    for (int m = 0; m < LAT + 3; m++) begin
      if (done) dones++;
      tick();
    end
    checks++; if (dones != 0) $display("FAIL midrst_no_done: got %0d want 0", dones); else passes++;
    f_model = $urandom; flag_model = 8'($urandom);
    do_start(3'd3, 3'd5);
    wait_done(n);
    checks++; if (n != LAT) $display("FAIL midrst_rerun_latency: got %0d want %0d", n, LAT); else passes++;
    checks++; if (result !== f_model) $display("FAIL midrst_rerun_result: got %h want %h", result, f_model); else passes++;
    checks++; if (flags !== exp_flags(flag_model)) $display("FAIL midrst_rerun_flags: got %h want %h", flags, exp_flags(flag_model)); else passes++;
    checks++; if (ALU_OP !== 3'd3) $display("FAIL midrst_rerun_alu_op: got %0d want 3", ALU_OP); else passes++;
    tick();
  endtask

  task automatic test_back_to_back();
    int n;
    logic [2:0] op, ab;
    for (int it = 0; it < 6; it++) begin
      f_model = $urandom; flag_model = 8'($urandom);
      op = 3'($urandom); ab = 3'($urandom);
      do_start(op, ab);
      wait_done(n);
      checks++; if (n != LAT) $display("FAIL b2b%0d_latency: got %0d want %0d", it, n, LAT); else passes++;
      checks++; if (result !== f_model) $display("FAIL b2b%0d_result: got %h want %h", it, result, f_model); else passes++;
      checks++; if (flags !== exp_flags(flag_model)) $display("FAIL b2b%0d_flags: got %h want %h", it, flags, exp_flags(flag_model)); else passes++;
      checks++; if ({ALU_OP, AB_SW} !== {op, ab}) $display("FAIL b2b%0d_ops: got %0d/%0d want %0d/%0d", it, ALU_OP, AB_SW, op, ab); else passes++;
      tick();
      checks++; if (busy !== 1'b0) $display("FAIL b2b%0d_idle: got %b want 0", it, busy); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_select_seq();
    test_start_while_busy();
    test_sampling_window();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
